// File: rtl/div_unit.sv
// div_unit: 32-bit RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one bit per cycle.
// Optional DIV_EARLY_OUT_EN: a divide by zero skips the iteration loop.
module div_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  input  logic [1:0]  i_div_op,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_div_data
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d, data_d;
  logic        is_rem_q, is_rem_d, sa_q, sa_d, sb_q, sb_d, valid_d;
  logic        sgn, ge;
  logic [31:0] mag_a, mag_b, q_res, r_res;
  logic [32:0] sh;
  assign o_busy = state_q != IDLE;
  always_comb begin
    sgn   = ~i_div_op[0];
    mag_a = (sgn && i_operand_a[31]) ? -i_operand_a : i_operand_a;
    mag_b = (sgn && i_operand_b[31]) ? -i_operand_b : i_operand_b;
    sh    = {rem_q, quot_q[31]};
    ge    = sh >= {1'b0, dvs_q};
    // a zero divisor yields all-ones quotient; its sign correction is suppressed
    q_res = ((sa_q ^ sb_q) && dvs_q != 32'd0) ? -quot_q : quot_q;
    r_res = sa_q ? -rem_q : rem_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    is_rem_d = is_rem_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    valid_d  = 1'b0;
    data_d   = o_div_data;
    if (state_q == IDLE) begin
      if (i_start) begin
        state_d  = CALC;
        is_rem_d = i_div_op[1];
        sa_d     = sgn & i_operand_a[31];
        sb_d     = sgn & i_operand_b[31];
        dvs_d    = mag_b;
        rem_d    = 32'd0;
        quot_d   = mag_a;
        cnt_d    = 6'd32;
`ifdef DIV_EARLY_OUT_EN
        // preload the divide-by-zero result and skip straight to the finishing cycle
        if (i_operand_b == 32'd0) begin
          rem_d  = mag_a;
          quot_d = '1;
          cnt_d  = 6'd0;
        end
`endif
      end
    end else if (state_q == CALC) begin
      if (cnt_q == 6'd0) begin
        state_d = DONE;
        valid_d = 1'b1;
        data_d  = is_rem_q ? r_res : q_res;
      end else begin
        rem_d  = ge ? sh[31:0] - dvs_q : sh[31:0];
        quot_d = {quot_q[30:0], ge};
        cnt_d  = cnt_q - 6'd1;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      rem_q      <= 32'd0;
      quot_q     <= 32'd0;
      dvs_q      <= 32'd0;
      is_rem_q   <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      o_valid    <= 1'b0;
      o_div_data <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      is_rem_q   <= is_rem_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      o_valid    <= valid_d;
      o_div_data <= data_d;
    end
  end
endmodule
